data_mem_responder: RTL and testbench

- Responder end of the load/store data-memory interface driven by the ld/sd datapath.
- Accepts one doubleword read or write request at a time over a valid/ready handshake.
- Services it after a fixed programmable latency and returns a response over a second valid/ready handshake.
- Replaces the zero-latency combinational data memory, so the pipeline and its bench can exercise stall behaviour.

---
 rtl/data_mem_responder.sv | 141 ++++++++++++++
 tb/tb_data_mem_responder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: one 64-bit load/store at a time over req/resp valid-ready handshakes.
// Latency: resp_valid rises LATENCY edges after acceptance (LATENCY in 1..15); throughput one request per LATENCY+2 cycles.
// Backpressure: req_ready is low outside IDLE; the response is held stable while resp_ready is low.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_error,
    output logic        busy
);

    // Index width into the storage array.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Remaining WAIT cycles; the response is produced on the edge where this is zero.
    logic [3:0]  cnt;

    // Request captured at acceptance; later changes on req_* are ignored.
    logic        cap_write;
    logic [63:0] cap_addr;
    logic [63:0] cap_wdata;

    // Storage is deliberately left out of reset.
    logic [63:0] mem [DEPTH];

    logic [60:0]   index;
    logic [AW-1:0] mem_idx;
    logic          addr_err;
    logic          fire;

    // Doubleword index and request legality, derived from the captured address.
    assign index    = cap_addr[63:3];
    assign mem_idx  = index[AW-1:0];
    assign addr_err = (cap_addr[2:0] != 3'd0) || (index >= 61'(DEPTH));

    // The single memory access of a request happens on the WAIT->RESP edge.
    assign fire     = (state == WAIT) && (cnt == 4'd0);

    // Next-state selection and handshake outputs decoded from the current state.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset abandons any request in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the request on acceptance and count down the service latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= 4'd0;
            cap_write <= 1'b0;
            cap_addr  <= 64'd0;
            cap_wdata <= 64'd0;
        end else begin
            if (state == IDLE && req_valid) begin
                cnt       <= 4'(LATENCY - 1);
                cap_write <= req_write;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Response registers: loaded when the access fires, held through RESP, cleared on consumption.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_rdata <= 64'd0;
            resp_error <= 1'b0;
        end else begin
            if (fire) begin
                resp_error <= addr_err;
                // Loads see the array contents before any write on this edge.
                resp_rdata <= (!addr_err && !cap_write) ? mem[mem_idx] : 64'd0;
            end else if (state == RESP && resp_ready) begin
                resp_rdata <= 64'd0;
                resp_error <= 1'b0;
            end
        end
    end

    // Store commit on the WAIT->RESP edge; illegal addresses never touch the array.
    always_ff @(posedge clock) begin
        if (fire && cap_write && !addr_err) begin
            mem[mem_idx] <= cap_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY 2 and 1) driven by directed and random requests.
// Expected responses come from an array model and are queued at acceptance; a monitor pops at resp_valid rise.
// Each negedge the monitor also checks hold/clear behaviour and that req_ready and resp_valid never overlap.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT0  = 2;
    localparam int LAT1  = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [63:0] req_addr   [2];
    logic [63:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        rr_dir     [2];
    logic        rr_rand = 1'b1;
    logic        rand_rr = 1'b0;
    logic [63:0] resp_rdata [2];
    logic        resp_error [2];
    logic        busy       [2];

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        logic        chk_data;
        int          acc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [63:0] ref_mem [2][DEPTH];
    bit          known   [2][DEPTH];
    logic        prev_v  [2];
    logic [63:0] hold_d  [2];
    logic        hold_e  [2];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) if (rand_rr) rr_rand = ($urandom_range(0, 3) != 0);

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) u_dut0 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(rand_rr ? rr_rand : rr_dir[0]),
        .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]), .busy(busy[0])
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) u_dut1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(rr_dir[1]),
        .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]), .busy(busy[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Behavioural reference: doubleword array; error on misalignment or index beyond DEPTH.
    function automatic exp_t model(input int g, input logic w, input logic [63:0] a,
                                   input logic [63:0] d, input int acc);
        exp_t e;
        longint unsigned idx;
        int ii;
        idx        = a >> 3;
        e.acc      = acc;
        e.chk_data = 1'b1;
        e.rdata    = 64'd0;
        e.err      = (a % 8 != 0) || (idx >= DEPTH);
        if (!e.err) begin
            ii = int'(idx);
            if (w) begin
                ref_mem[g][ii] = d;
                known[g][ii]   = 1'b1;
            end else begin
                e.rdata    = ref_mem[g][ii];
                e.chk_data = known[g][ii];
            end
        end
        return e;
    endfunction

    task automatic mon_step(input int g);
        exp_t e;
        int   lat;
        lat = (g == 0) ? LAT0 : LAT1;
        chk($sformatf("d%0d_busy", g), 64'(busy[g]), 64'(!req_ready[g]));
        chk($sformatf("d%0d_ready_with_valid", g), 64'(resp_valid[g] && req_ready[g]), 64'd0);
        if (resp_valid[g] && !prev_v[g]) begin
            if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
                fail_now($sformatf("d%0d_unexpected_response", g));
            end else begin
                if (g == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("d%0d_latency", g), 64'(cyc), 64'(e.acc + lat));
                chk($sformatf("d%0d_error", g), 64'(resp_error[g]), 64'(e.err));
                if (e.chk_data) chk($sformatf("d%0d_rdata", g), resp_rdata[g], e.rdata);
            end
            hold_d[g] = resp_rdata[g];
            hold_e[g] = resp_error[g];
        end else if (resp_valid[g]) begin
            chk($sformatf("d%0d_hold_rdata", g), resp_rdata[g], hold_d[g]);
            chk($sformatf("d%0d_hold_error", g), 64'(resp_error[g]), 64'(hold_e[g]));
        end else begin
            chk($sformatf("d%0d_idle_rdata", g), resp_rdata[g], 64'd0);
            chk($sformatf("d%0d_idle_error", g), 64'(resp_error[g]), 64'd0);
        end
        prev_v[g] = resp_valid[g];
    endtask

    always @(negedge clock) begin
        if (reset) begin
            prev_v[0] = 1'b0;
            prev_v[1] = 1'b0;
        end else begin
            mon_step(0);
            mon_step(1);
        end
    end

    // Present a request and hold it until accepted; called and returns just after a negedge.
    task automatic issue(input int g, input logic w, input logic [63:0] a,
                         input logic [63:0] d, input bit track);
        int   t;
        exp_t e;
        t = 0;
        req_valid[g] = 1'b1;
        req_write[g] = w;
        req_addr[g]  = a;
        req_wdata[g] = d;
        while (!req_ready[g] && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (!req_ready[g]) begin
            fail_now($sformatf("d%0d_accept_timeout", g));
        end else if (track) begin
            e = model(g, w, a, d, cyc + 1);
            if (g == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clock);
        req_valid[g] = 1'b0;
        req_write[g] = ~w;
        req_addr[g]  = {$urandom, $urandom};
        req_wdata[g] = {$urandom, $urandom};
    endtask

    task automatic drain(input int g);
        int t;
        t = 0;
        while (((g == 0 ? q0.size() : q1.size()) != 0 || resp_valid[g]) && t < 300) begin
            @(negedge clock);
            t++;
        end
        if (t >= 300) fail_now($sformatf("d%0d_drain_timeout", g));
    endtask

    task automatic rst_chk(input int g);
        chk($sformatf("d%0d_rst_req_ready", g), 64'(req_ready[g]), 64'd1);
        chk($sformatf("d%0d_rst_resp_valid", g), 64'(resp_valid[g]), 64'd0);
        chk($sformatf("d%0d_rst_rdata", g), resp_rdata[g], 64'd0);
        chk($sformatf("d%0d_rst_error", g), 64'(resp_error[g]), 64'd0);
        chk($sformatf("d%0d_rst_busy", g), 64'(busy[g]), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_expired (cycle %0d)", cyc);
        $fatal(1, "bench watchdog");
    end

    initial begin
        int          t;
        int          n;
        int          last;
        int          r;
        logic [63:0] a;
        exp_t        e;

        for (int g = 0; g < 2; g++) begin
            req_valid[g] = 1'b0;
            req_write[g] = 1'b0;
            req_addr[g]  = 64'd0;
            req_wdata[g] = 64'd0;
            rr_dir[g]    = 1'b1;
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        rst_chk(0);
        rst_chk(1);
        reset = 1'b0;
        @(negedge clock);

        // Store then load at 0x10.
        issue(0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 1'b1);
        issue(0, 1'b0, 64'h10, 64'd0, 1'b1);
        drain(0);

        // Give indexes 0..15 known contents.
        for (int i = 0; i < 16; i++) begin
            if (i != 2) issue(0, 1'b1, 64'(i) * 8, {$urandom, $urandom}, 1'b1);
        end
        drain(0);

        // Backpressure: response held while resp_ready is low; requests meanwhile are refused.
        rr_dir[0] = 1'b0;
        issue(0, 1'b0, 64'h10, 64'd0, 1'b1);
        t = 0;
        while (!resp_valid[0] && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!resp_valid[0]) fail_now("bp_response_timeout");
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_held", 64'(resp_valid[0]), 64'd1);
            chk("bp_req_refused", 64'(req_ready[0]), 64'd0);
            req_valid[0] = (i % 2 == 0);
            req_write[0] = 1'b0;
            req_addr[0]  = 64'h18;
            @(negedge clock);
        end
        req_valid[0] = 1'b0;
        rr_dir[0]    = 1'b1;
        @(negedge clock);
        chk("bp_idle_ready", 64'(req_ready[0]), 64'd1);
        chk("bp_valid_dropped", 64'(resp_valid[0]), 64'd0);

        // Misaligned load, out-of-range store, then memory untouched at 0x0.
        issue(0, 1'b0, 64'h13, 64'd0, 1'b1);
        issue(0, 1'b1, 64'h800, {$urandom, $urandom}, 1'b1);
        issue(0, 1'b0, 64'h0, 64'd0, 1'b1);
        drain(0);

        // Reset during WAIT drops the store.
        issue(0, 1'b1, 64'h20, 64'h1, 1'b0);
        reset = 1'b1;
        #1;
        rst_chk(0);
        @(negedge clock);
        rst_chk(0);
        q0.delete();
        reset = 1'b0;
        @(negedge clock);
        issue(0, 1'b0, 64'h20, 64'd0, 1'b1);
        drain(0);

        // Top index round-trip on the LATENCY=1 instance.
        issue(1, 1'b1, 64'h7F8, {$urandom, $urandom}, 1'b1);
        issue(1, 1'b0, 64'h7F8, 64'd0, 1'b1);
        drain(1);

        // Back-to-back loads with req_valid and resp_ready held high.
        n    = 0;
        last = 0;
        t    = 0;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 64'($urandom_range(0, 15)) * 8;
        while (n < 10 && t < 200) begin
            if (req_ready[0]) begin
                e = model(0, 1'b0, req_addr[0], 64'd0, cyc + 1);
                q0.push_back(e);
                if (n > 0) chk("tput_interval", 64'(cyc + 1 - last), 64'd4);
                last = cyc + 1;
                n++;
                @(negedge clock);
                req_addr[0] = 64'($urandom_range(0, 15)) * 8;
                if (n == 10) req_valid[0] = 1'b0;
            end else begin
                @(negedge clock);
            end
            t++;
        end
        req_valid[0] = 1'b0;
        if (n < 10) fail_now("tput_accept_count");
        drain(0);

        // Random mix with random response backpressure.
        rand_rr = 1'b1;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       a = 64'($urandom_range(0, 15)) * 8;
            else if (r == 6) a = 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(1, 7));
            else if (r == 7) a = 64'($urandom_range(256, 4095)) * 8;
            else if (r == 8) a = {1'b1, 63'($urandom)} & ~64'd7;
            else             a = 64'h7F8;
            issue(0, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 1'b1);
        end
        drain(0);
        rand_rr = 1'b0;
        @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
